pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//   Parametrised stall/flush/valid controller for an N-register in-order pipeline; replaces the
//   fixed five-stage combinational control. Tracks a valid bit per pipeline register, derives
//   per-register stall/flush from per-stage busy/hazard inputs, applies branch redirect and
//   commit-stage trap kills, and keeps cycle/instret counters for difftest and CSRs.
// PARAMETERS
//   NSTAGE    5   pipeline registers R[0..NSTAGE-1]; R[i] holds stage i result, R[NSTAGE-1] commits
//   RS        2   stage index resolving redirects (1 <= RS <= NSTAGE-2)
//   CNT_W     64  width of cycle_cnt / instret_cnt
// PORTS
//   clk          in   1        clock
//   reset        in   1        asynchronous, active-low reset
//   in_valid     in   1        fetch (stage 0) has an instruction this cycle
//   busy         in   NSTAGE   stage i has not finished its work (bus wait, multi-cycle op)
//   hazard       in   NSTAGE   stage i must not consume R[i-1] this cycle (load-use, CSR serialise)
//   redirect     in   1        stage RS requests a redirect (taken branch/jump)
//   trap         in   1        instruction in R[NSTAGE-1] traps; flush everything
//   stall        out  NSTAGE   R[i] holds its contents
//   flush        out  NSTAGE   R[i] loads a bubble
//   valid        out  NSTAGE   R[i] holds a live instruction (registered)
//   pc_en        out  1        PC register updates this cycle
//   pc_load      out  2        PC source: 0 seq, 1 redirect target, 2 trap vector
//   retire       out  1        instruction in R[NSTAGE-1] commits this cycle
//   cycle_cnt    out  CNT_W    cycles since reset
//   instret_cnt  out  CNT_W    retired instructions since reset
// BEHAVIOUR
//   - Reset (asserted low, async): valid=0, cycle_cnt=0, instret_cnt=0. Combinational outputs
//     follow from valid=0: stall=0, retire=0.
//   - accept[NSTAGE-1]=1; accept[i]=!valid[i] | take[i+1]. take[i]=accept[i]&!busy[i]&!hazard[i].
//     Chain is acyclic (evaluated from last stage down); no combinational loop permitted.
//   - stall[i]=!accept[i]. take[i]: valid[i]<=(i==0 ? in_valid : valid[i-1]).
//     accept[i]&!take[i]: bubble, flush[i]=1, valid[i]<=0.
//   - retire=valid[NSTAGE-1]&!trap. R[NSTAGE-1] is consumed every cycle: each instruction retires
//     exactly once; busy at last stage inserts bubbles, never duplicates.
//   - redirect honoured (redir_ok) only if take[RS]&valid[RS-1]; else ignored, requester holds it.
//     redir_ok: flush[i]=1, valid[i]<=0 for i<RS; wrong-path fetch dropped; pc_en=1, pc_load=1.
//   - trap (qualified by valid[NSTAGE-1]): flush all R[i], valid<=0, pc_en=1, pc_load=2; trapping
//     instruction does not retire. Trap beats redirect in the same cycle.
//   - Otherwise pc_en=take[0], pc_load=0. stall and flush never both 1 for one register
//     (flush wins, stall forced 0).
//   - cycle_cnt +1 every cycle; instret_cnt +1 when retire. Both wrap at 2^CNT_W silently.
//   - Latency: instruction entering with take[0] reaches retire after NSTAGE-1 further takes;
//     empty pipe, no busy: retire NSTAGE cycles after entry.
// STRUCTURE
//   - pipes package: stage_vec_t (logic [NSTAGE-1:0]), pc_sel_t enum {PC_SEQ, PC_REDIR, PC_TRAP}.
//   - One sub-module: perf_counter (CNT_W, async active-low reset, inc enable), instanced twice.
//   - Rest is one always_comb for accept/take chain and one always_ff for valid.
// TESTING  (NSTAGE=5, RS=2)
//   - reset low 3 cycles, in_valid=1 -> valid=0, counters 0; after release valid fills 00001,
//     00011..11111; retire first high on 5th cycle, then every cycle; instret_cnt=6 after 10 cycles.
//   - full pipe, busy[3]=1 for 3 cycles -> stall[2:0]=111, flush[3]=1 each cycle, retire gap of
//     3 cycles, instret delta equals instructions entered (none lost or duplicated).
//   - hazard[2]=1 one cycle -> stall[1:0]=11, flush[2]=1, pc_en=0, exactly one bubble retires.
//   - redirect with valid[1]=1, no busy -> flush[1:0]=11, pc_en=1, pc_load=1; next cycle
//     valid[1:0]=00, valid[2]=1.
//   - redirect and trap same cycle -> flush=11111, pc_load=2, retire=0, next valid=00000.
//   - redirect while busy[2]=1 -> ignored: flush[1:0]=00, pc_load=0; honoured when busy drops;
//     reset pulse mid-stream -> valid=0 and counters 0 without waiting for clk edge.

Source files
------------

// File: rtl/pipes_pkg.sv
// Shared types for the in-order pipeline controller: stage vectors and PC source select.
package pipes_pkg;

  localparam int NSTAGE_DEF = 5;

  typedef logic [NSTAGE_DEF-1:0] stage_vec_t;

  typedef enum logic [1:0] {
    PC_SEQ   = 2'd0,
    PC_REDIR = 2'd1,
    PC_TRAP  = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with enable; wraps silently at 2^W.
module perf_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (inc) count <= count + W'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/valid controller for an NSTAGE-register in-order pipeline with redirect, trap
// kill and cycle/instret counters.
module pipeline_ctrl
  import pipes_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int RS     = 2,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [NSTAGE-1:0] busy,
  input  logic [NSTAGE-1:0] hazard,
  input  logic              redirect,
  input  logic              trap,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic [NSTAGE-1:0] valid,
  output logic              pc_en,
  output logic [1:0]        pc_load,
  output logic              retire,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);

  logic [NSTAGE-1:0] accept;
  logic [NSTAGE-1:0] take;
  logic              trap_q;
  logic              redir_ok;
  pc_sel_t           pc_sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    accept = '0;
    take   = '0;
    flush  = '0;
    stall  = '0;
    pc_sel = PC_SEQ;
    pc_en  = 1'b0;

    // The commit register drains every cycle; the chain then runs back towards fetch so no
    // bit depends on a lower-indexed one and no loop can form.
    accept[NSTAGE-1] = 1'b1;
    take[NSTAGE-1]   = !busy[NSTAGE-1] && !hazard[NSTAGE-1];
    for (int i = NSTAGE - 2; i >= 0; i--) begin
      accept[i] = !valid[i] || take[i+1];
      take[i]   = accept[i] && !busy[i] && !hazard[i];
    end

    trap_q   = trap && valid[NSTAGE-1];
    redir_ok = redirect && take[RS] && valid[RS-1] && !trap_q;

    for (int i = 0; i < NSTAGE; i++) begin
      if (trap_q)                 flush[i] = 1'b1;
      else if (redir_ok && i < RS) flush[i] = 1'b1;
      else                        flush[i] = accept[i] && !take[i];
      stall[i] = !accept[i] && !flush[i];
    end

    if (trap_q) begin
      pc_en  = 1'b1;
      pc_sel = PC_TRAP;
    end else if (redir_ok) begin
      pc_en  = 1'b1;
      pc_sel = PC_REDIR;
    end else begin
      pc_en  = take[0];
      pc_sel = PC_SEQ;
    end
  end

  assign pc_load = pc_sel;
  assign retire  = valid[NSTAGE-1] && !trap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (flush[i])     valid[i] <= 1'b0;
        else if (take[i]) valid[i] <= (i == 0) ? in_valid : valid[i-1];
      end
    end
  end

  perf_counter #(.W(CNT_W)) u_cycle (
    .clk   (clk),
    .rst_n (reset),
    .inc   (1'b1),
    .count (cycle_cnt)
  );

  perf_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst_n (reset),
    .inc   (retire),
    .count (instret_cnt)
  );

endmodule
